nonce_queue: RTL and testbench
==============================

Name: nonce_queue

Overview:
- Sits between the per-slave nonce sources (local miners and external-port slave receivers) and the serial nonce transmitter in the cluster hub.
- Captures every golden-nonce pulse from SLAVES sources into per-slave holding slots, arbitrates them round-robin into a FIFO, and drains the FIFO one 32-bit word at a time through the transmitter's send/busy handshake.
- Guarantees no nonce is dropped while the transmitter is busy, unless a slot or the FIFO is overrun; overruns are counted.

Parameters:
- SLAVES, 5, number of nonce sources (local miners + external ports).
- DEPTH_LOG2, 3, FIFO depth is 2**DEPTH_LOG2 words of 32 bits.
- ACK_TIMEOUT, 4, cycles to wait for serial_busy to rise after a send before treating the word as sent.

Ports:
- hash_clk  in  1  sole clock; all logic on its rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- slave_nonces  in  SLAVES*32  nonce of slave i on bits [i*32+31:i*32].
- new_nonces  in  SLAVES  one-cycle pulse per slave; its nonce is valid in the same cycle.
- golden_nonce  out  32  word presented to the transmitter.
- serial_send  out  1  one-cycle send strobe.
- serial_busy  in  1  transmitter busy.
- fifo_level  out  DEPTH_LOG2+1  current FIFO occupancy, 0..2**DEPTH_LOG2.
- lost_count  out  16  saturating count of nonces lost to overrun.

Behaviour:
- Reset (reset_n=0 at a clock edge): all slots not pending, FIFO empty, fifo_level=0, golden_nonce=0, serial_send=0, lost_count=0, arbiter pointer=0, TX FSM=IDLE. Reset mid-transmission abandons the word with no further send.
- Capture: on new_nonces[i]=1, slot i is loaded with the nonce and pending[i] is set.
  - If pending[i] was already 1 and is not being drained this cycle, the old value is overwritten and lost_count increments.
  - If slot i is being drained in the same cycle, the old value goes to the FIFO, the new value is loaded, pending[i] stays 1, and no loss is counted.
  - Simultaneous pulses on several slaves are all captured in the same cycle.
- Arbiter:
  - Each cycle with the FIFO not full (or popping this cycle), it pushes the first pending slot at or after the pointer (wrapping modulo SLAVES), clears that slot's pending bit, and sets the pointer to the chosen index + 1, wrapping at SLAVES.
  - One push per cycle maximum.
  - When the FIFO is full and not popping, slots stay pending and nothing is lost at the arbiter.
- Latency: a new_nonces pulse into an idle, empty system reaches the FIFO after 2 cycles (capture, push). serial_send asserts on the following cycle.
- FIFO: synchronous, first-word fall-through not required.
  - Push and pop in the same cycle when full is legal and leaves the level unchanged.
  - Pop when empty never happens.
  - Pointers wrap modulo 2**DEPTH_LOG2.
- TX FSM:
  - IDLE: if the FIFO is non-empty and serial_busy=0, pop the head into golden_nonce and go to SEND.
  - SEND: serial_send=1 for exactly this cycle; golden_nonce is held stable; go to WAIT_HI with the timer cleared.
  - WAIT_HI: if serial_busy=1, go to WAIT_LO. Otherwise the timer increments; when it reaches ACK_TIMEOUT, go to IDLE.
  - WAIT_LO: when serial_busy=0, go to IDLE.
  - golden_nonce holds its value until the next pop.
- lost_count saturates at 16'hFFFF.

Optional Feature:
- Macro: NONCE_QUEUE_DEDUP_EN.
- When defined: the block keeps a last-pushed register (valid flag cleared on reset). A word identical to the last word pushed to the FIFO is discarded at the arbiter: the slot is cleared, nothing is pushed, and lost_count is unchanged. This suppresses duplicate reports from slaves sharing a nonce range.
- When undefined: every captured nonce is pushed, and no compare logic or register exists.

Decomposition:
- Shared package constants: TX FSM state encodings (IDLE, SEND, WAIT_HI, WAIT_LO), nonce width 32, lost_count width 16.
- One natural sub-module: nonce_fifo, a parameterised synchronous 32-bit FIFO.
  - Ports: hash_clk, reset_n, push, din, pop, dout, level, full, empty.
- Capture, arbiter and TX FSM stay in nonce_queue.

Test Plan:
- Single nonce: after reset, pulse new_nonces[2] with 32'hDEADBEEF, serial_busy held low -> serial_send pulses once, 3 cycles after the pulse, with golden_nonce=32'hDEADBEEF; with no busy response the FSM is back in IDLE after 4 WAIT_HI cycles.
- Simultaneous sources: one-cycle pulse on all 5 slaves with nonces 1..5; transmitter model holds busy for 10 cycles per word -> words are sent in order 1,2,3,4,5 (pointer 0), fifo_level peaks at 5, lost_count=0.
- Slot overrun: serial_busy stuck high, FIFO filled to 8; pulse slave 0 twice with 32'hA then 32'hB -> lost_count=1; after busy is released, 32'hB is eventually sent and 32'hA is never sent.
- Drain/capture collision: slave 1 pending with 32'h11 and selected by the arbiter in the same cycle as a new pulse carrying 32'h22 -> both are sent, 32'h11 first, lost_count=0.
- Reset mid-operation: reset_n=0 for 1 cycle while in WAIT_LO with 3 words queued -> fifo_level=0, serial_send=0, golden_nonce=0, and no further sends.
- Dedup (NONCE_QUEUE_DEDUP_EN): slaves 3 and 4 both report 32'h1234 in consecutive cycles -> one send only; without the macro, two sends.

Source files
------------

// File: rtl/nonce_queue_pkg.sv
// nonce_queue_pkg: constants and types shared by the nonce queue, its FIFO
// and the transmitter interface. Optional build macro: NONCE_QUEUE_DEDUP_EN.
package nonce_queue_pkg;

    localparam int NONCE_W = 32;
    localparam int LOST_W  = 16;

    typedef enum logic [1:0] {
        TX_IDLE    = 2'd0,
        TX_SEND    = 2'd1,
        TX_WAIT_HI = 2'd2,
        TX_WAIT_LO = 2'd3
    } txState_t;

    // Adds two loss counts, clamping at all-ones instead of wrapping.
    function automatic logic [LOST_W-1:0] satAdd(input logic [LOST_W-1:0] base,
                                                 input logic [LOST_W-1:0] inc);
        logic [LOST_W:0] sum;
        sum = {1'b0, base} + {1'b0, inc};
        return sum[LOST_W] ? {LOST_W{1'b1}} : sum[LOST_W-1:0];
    endfunction

endpackage

// File: rtl/nonce_queue_if.sv
// nonce_queue_if: send/busy handshake between the nonce queue (master)
// and the serial nonce transmitter (slave).
interface nonce_queue_if;
    import nonce_queue_pkg::*;

    logic [NONCE_W-1:0] golden_nonce;
    logic               serial_send;
    logic               serial_busy;

    modport master (output golden_nonce, output serial_send, input serial_busy);
    modport slave  (input golden_nonce, input serial_send, output serial_busy);

endinterface

// File: rtl/nonce_fifo.sv
// nonce_fifo: synchronous 32-bit FIFO of 2**DEPTH_LOG2 words. The head word
// is always visible on dout so a pop can capture it in the same cycle.
module nonce_fifo
    import nonce_queue_pkg::*;
#(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  hash_clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic [NONCE_W-1:0]    din,
    input  logic                  pop,
    output logic [NONCE_W-1:0]    dout,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [NONCE_W-1:0]    r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wrPtr;
    logic [DEPTH_LOG2-1:0] r_rdPtr;
    logic [DEPTH_LOG2:0]   r_level;
    logic                  w_doPush;
    logic                  w_doPop;

    assign full     = (r_level == (DEPTH_LOG2+1)'(DEPTH));
    assign empty    = (r_level == '0);
    assign level    = r_level;
    assign dout     = r_mem[r_rdPtr];
    assign w_doPop  = pop && !empty;
    assign w_doPush = push && (!full || w_doPop);

    // Storage array; written at the write pointer, no reset needed.
    always_ff @(posedge hash_clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= din;
        end
    end

    // Pointers wrap naturally at DEPTH; level tracks push minus pop.
    always_ff @(posedge hash_clk) begin
        if (!reset_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
            case ({w_doPush, w_doPop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/nonce_queue.sv
// nonce_queue: captures golden-nonce pulses from SLAVES sources into holding
// slots, arbitrates them round-robin into a FIFO and drains the FIFO through
// the transmitter send/busy handshake. Optional macro NONCE_QUEUE_DEDUP_EN
// drops a word equal to the previous word pushed.
module nonce_queue
    import nonce_queue_pkg::*;
#(
    parameter int SLAVES      = 5,
    parameter int DEPTH_LOG2  = 3,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic                      hash_clk,
    input  logic                      reset_n,
    input  logic [SLAVES*NONCE_W-1:0] slave_nonces,
    input  logic [SLAVES-1:0]         new_nonces,
    nonce_queue_if.master             tx,
    output logic [DEPTH_LOG2:0]       fifo_level,
    output logic [LOST_W-1:0]         lost_count
);

    localparam int PTR_W = (SLAVES > 1) ? $clog2(SLAVES) : 1;
    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

    logic [NONCE_W-1:0] r_slot [SLAVES];
    logic [SLAVES-1:0]  r_pending;
    logic [PTR_W-1:0]   r_ptr;
    txState_t           r_state;
    logic [TMR_W-1:0]   r_timer;
    logic [NONCE_W-1:0] r_golden;
    logic               r_send;
    logic [LOST_W-1:0]  r_lost;

    logic               w_selValid;
    logic [PTR_W-1:0]   w_sel;
    logic               w_grant;
    logic               w_push;
    logic               w_pop;
    logic               w_fifoFull;
    logic               w_fifoEmpty;
    logic [NONCE_W-1:0] w_fifoDout;
    logic [LOST_W-1:0]  w_lossCnt;

    // Slot index base+offset, wrapped modulo SLAVES.
    function automatic logic [PTR_W-1:0] wrapIdx(input logic [PTR_W-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= SLAVES) sum = sum - SLAVES;
        return PTR_W'(sum);
    endfunction

    nonce_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
        .hash_clk (hash_clk),
        .reset_n  (reset_n),
        .push     (w_push),
        .din      (r_slot[w_sel]),
        .pop      (w_pop),
        .dout     (w_fifoDout),
        .level    (fifo_level),
        .full     (w_fifoFull),
        .empty    (w_fifoEmpty)
    );

    assign w_pop   = (r_state == TX_IDLE) && !w_fifoEmpty && !tx.serial_busy;
    assign w_grant = w_selValid && (!w_fifoFull || w_pop);

`ifdef NONCE_QUEUE_DEDUP_EN
    logic [NONCE_W-1:0] r_lastWord;
    logic               r_lastValid;
    logic               w_dup;

    assign w_dup  = r_lastValid && (r_lastWord == r_slot[w_sel]);
    assign w_push = w_grant && !w_dup;

    // Remember the last word actually pushed so a repeat can be discarded.
    always_ff @(posedge hash_clk) begin
        if (!reset_n) begin
            r_lastValid <= 1'b0;
            r_lastWord  <= '0;
        end else if (w_push) begin
            r_lastValid <= 1'b1;
            r_lastWord  <= r_slot[w_sel];
        end
    end
`else
    assign w_push = w_grant;
`endif

    // Pick the first pending slot at or after the round-robin pointer.
    always_comb begin
        w_selValid = 1'b0;
        w_sel      = '0;
        for (int k = SLAVES - 1; k >= 0; k--) begin
            if (r_pending[wrapIdx(r_ptr, k)]) begin
                w_selValid = 1'b1;
                w_sel      = wrapIdx(r_ptr, k);
            end
        end
    end

    // Count slots overwritten while still pending and not drained this cycle.
    always_comb begin
        w_lossCnt = '0;
        for (int i = 0; i < SLAVES; i++) begin
            w_lossCnt = w_lossCnt + LOST_W'(new_nonces[i] && r_pending[i] &&
                                            !(w_grant && (w_sel == PTR_W'(i))));
        end
    end

    // Load slots on new pulses; a granted slot clears unless reloaded now.
    always_ff @(posedge hash_clk) begin
        if (!reset_n) begin
            r_pending <= '0;
            for (int i = 0; i < SLAVES; i++) r_slot[i] <= '0;
        end else begin
            for (int i = 0; i < SLAVES; i++) begin
                if (new_nonces[i]) begin
                    r_slot[i]    <= slave_nonces[i*NONCE_W +: NONCE_W];
                    r_pending[i] <= 1'b1;
                end else if (w_grant && (w_sel == PTR_W'(i))) begin
                    r_pending[i] <= 1'b0;
                end
            end
        end
    end

    // Advance the arbiter pointer past each granted slot.
    always_ff @(posedge hash_clk) begin
        if (!reset_n) begin
            r_ptr <= '0;
        end else if (w_grant) begin
            r_ptr <= (w_sel == PTR_W'(SLAVES - 1)) ? '0 : w_sel + 1'b1;
        end
    end

    // Saturating tally of nonces lost to slot overrun.
    always_ff @(posedge hash_clk) begin
        if (!reset_n) begin
            r_lost <= '0;
        end else begin
            r_lost <= satAdd(r_lost, w_lossCnt);
        end
    end

    // Transmit sequencer: pop, strobe send, wait for busy rise or timeout, wait for busy fall.
    always_ff @(posedge hash_clk) begin
        if (!reset_n) begin
            r_state  <= TX_IDLE;
            r_timer  <= '0;
            r_golden <= '0;
            r_send   <= 1'b0;
        end else begin
            case (r_state)
                TX_IDLE: begin
                    r_send <= 1'b0;
                    if (w_pop) begin
                        r_golden <= w_fifoDout;
                        r_send   <= 1'b1;
                        r_state  <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    r_send  <= 1'b0;
                    r_timer <= '0;
                    r_state <= TX_WAIT_HI;
                end
                TX_WAIT_HI: begin
                    if (tx.serial_busy) begin
                        r_state <= TX_WAIT_LO;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                        if (r_timer == TMR_W'(ACK_TIMEOUT - 1)) r_state <= TX_IDLE;
                    end
                end
                TX_WAIT_LO: begin
                    if (!tx.serial_busy) r_state <= TX_IDLE;
                end
                default: r_state <= TX_IDLE;
            endcase
        end
    end

    assign tx.golden_nonce = r_golden;
    assign tx.serial_send  = r_send;
    assign lost_count      = r_lost;

endmodule

// File: tb/tb_nonce_queue.sv
// tb_nonce_queue: directed scoreboard bench for nonce_queue. Expected words
// are queued as nonces are driven and checked as the transmitter sees sends.
module tb_nonce_queue;
    import nonce_queue_pkg::*;

    logic          hash_clk;
    logic          reset_n;
    logic [159:0]  slave_nonces;
    logic [4:0]    new_nonces;
    logic [3:0]    fifo_level;
    logic [15:0]   lost_count;

    nonce_queue_if txIf ();

    nonce_queue #(.SLAVES(5), .DEPTH_LOG2(3), .ACK_TIMEOUT(4)) dut (
        .hash_clk     (hash_clk),
        .reset_n      (reset_n),
        .slave_nonces (slave_nonces),
        .new_nonces   (new_nonces),
        .tx           (txIf),
        .fifo_level   (fifo_level),
        .lost_count   (lost_count)
    );

    int          checks = 0;
    int          errors = 0;
    int          sendCount = 0;
    int          busyMode = 0;
    int          busyCnt = 0;
    logic [31:0] sbQueue [$];

    initial hash_clk = 1'b0;
    always #5 hash_clk = ~hash_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] mask, input logic [159:0] words);
        @(negedge hash_clk);
        new_nonces   = mask;
        slave_nonces = words;
    endtask

    task automatic doReset();
        busyMode = 0;
        @(negedge hash_clk);
        reset_n    = 1'b0;
        new_nonces = '0;
        sbQueue.delete();
        repeat (2) @(negedge hash_clk);
        reset_n = 1'b1;
        @(negedge hash_clk);
    endtask

    task automatic waitSends(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (sendCount < target && n < budget) begin
            @(negedge hash_clk);
            n++;
        end
        checkOutput(tag, 32'(sendCount), 32'(target));
    endtask

    // Transmitter model and scoreboard consumer: checks every send, drives busy.
    initial begin
        txIf.serial_busy = 1'b0;
        forever begin
            @(negedge hash_clk);
            if (reset_n && txIf.serial_send) begin
                sendCount++;
                checkOutput("sb_has_entry", 32'(sbQueue.size() > 0), 32'd1);
                if (sbQueue.size() > 0) checkOutput("sent_word", txIf.golden_nonce, sbQueue.pop_front());
                if (busyMode == 1) busyCnt = 10;
            end
            if (busyMode == 2) begin
                txIf.serial_busy = 1'b1;
            end else if (busyMode == 1 && busyCnt > 0) begin
                txIf.serial_busy = 1'b1;
                busyCnt--;
            end else begin
                txIf.serial_busy = 1'b0;
                busyCnt = 0;
            end
        end
    end

    // Directed test sequence.
    initial begin
        logic [159:0] w;
        int base;
        int found;
        int expSends;
        reset_n      = 1'b0;
        new_nonces   = '0;
        slave_nonces = '0;
        repeat (3) @(negedge hash_clk);

        // Reset state
        checkOutput("rst_level", 32'(fifo_level), 32'd0);
        checkOutput("rst_send", 32'(txIf.serial_send), 32'd0);
        checkOutput("rst_golden", txIf.golden_nonce, 32'd0);
        checkOutput("rst_lost", 32'(lost_count), 32'd0);
        reset_n = 1'b1;
        @(negedge hash_clk);

        // Single nonce latency and ack timeout
        $display("[TB] single nonce");
        base = sendCount;
        w = '0;
        w[2*32 +: 32] = 32'hDEADBEEF;
        sbQueue.push_back(32'hDEADBEEF);
        applyStimulus(5'b00100, w);
        applyStimulus(5'b00000, w);
        checkOutput("lat_c1_send", 32'(txIf.serial_send), 32'd0);
        checkOutput("lat_c1_level", 32'(fifo_level), 32'd0);
        @(negedge hash_clk);
        checkOutput("lat_c2_send", 32'(txIf.serial_send), 32'd0);
        checkOutput("lat_c2_level", 32'(fifo_level), 32'd1);
        @(negedge hash_clk);
        checkOutput("lat_c3_send", 32'(txIf.serial_send), 32'd1);
        checkOutput("lat_c3_golden", txIf.golden_nonce, 32'hDEADBEEF);
        repeat (4) @(negedge hash_clk);
        checkOutput("wait_hi_last", 32'(dut.r_state), 32'(TX_WAIT_HI));
        @(negedge hash_clk);
        checkOutput("timeout_idle", 32'(dut.r_state), 32'(TX_IDLE));
        checkOutput("single_sends", 32'(sendCount), 32'(base + 1));
        checkOutput("golden_held", txIf.golden_nonce, 32'hDEADBEEF);

        // Simultaneous sources, pointer 0
        $display("[TB] simultaneous sources");
        doReset();
        base = sendCount;
        busyMode = 2;
        repeat (2) @(negedge hash_clk);
        for (int k = 0; k < 5; k++) begin
            w[k*32 +: 32] = 32'(k + 1);
            sbQueue.push_back(32'(k + 1));
        end
        applyStimulus(5'b11111, w);
        applyStimulus(5'b00000, w);
        repeat (5) @(negedge hash_clk);
        checkOutput("sim_level_peak", 32'(fifo_level), 32'd5);
        busyMode = 1;
        waitSends(base + 5, 300, "sim_sends");
        checkOutput("sim_lost", 32'(lost_count), 32'd0);

        // Slot overrun with a full FIFO
        $display("[TB] slot overrun");
        doReset();
        base = sendCount;
        busyMode = 2;
        repeat (2) @(negedge hash_clk);
        for (int k = 0; k < 8; k++) begin
            w = '0;
            w[1*32 +: 32] = 32'h100 + 32'(k);
            sbQueue.push_back(32'h100 + 32'(k));
            applyStimulus(5'b00010, w);
            applyStimulus(5'b00000, w);
        end
        repeat (3) @(negedge hash_clk);
        checkOutput("ovr_full", 32'(fifo_level), 32'd8);
        w = '0;
        w[31:0] = 32'hA;
        applyStimulus(5'b00001, w);
        applyStimulus(5'b00000, w);
        w[31:0] = 32'hB;
        applyStimulus(5'b00001, w);
        applyStimulus(5'b00000, w);
        checkOutput("ovr_lost", 32'(lost_count), 32'd1);
        checkOutput("ovr_level_hold", 32'(fifo_level), 32'd8);
        sbQueue.push_back(32'hB);
        busyMode = 0;
        waitSends(base + 9, 400, "ovr_sends");
        repeat (30) @(negedge hash_clk);
        checkOutput("ovr_no_extra", 32'(sendCount), 32'(base + 9));

        // Drain/capture collision on slave 1
        $display("[TB] drain capture collision");
        doReset();
        base = sendCount;
        w = '0;
        w[1*32 +: 32] = 32'h11;
        sbQueue.push_back(32'h11);
        applyStimulus(5'b00010, w);
        w[1*32 +: 32] = 32'h22;
        sbQueue.push_back(32'h22);
        applyStimulus(5'b00010, w);
        applyStimulus(5'b00000, w);
        checkOutput("col_lost", 32'(lost_count), 32'd0);
        waitSends(base + 2, 60, "col_sends");

        // Reset while in WAIT_LO with words queued
        $display("[TB] reset mid operation");
        doReset();
        base = sendCount;
        busyMode = 1;
        for (int k = 0; k < 4; k++) begin
            w[k*32 +: 32] = 32'h61 + 32'(k);
            sbQueue.push_back(32'h61 + 32'(k));
        end
        applyStimulus(5'b01111, w);
        applyStimulus(5'b00000, w);
        found = 0;
        for (int n = 0; n < 30 && found == 0; n++) begin
            @(negedge hash_clk);
            if (dut.r_state == TX_WAIT_LO && fifo_level == 4'd3) found = 1;
        end
        checkOutput("mid_reach_wait_lo", 32'(found), 32'd1);
        reset_n  = 1'b0;
        busyMode = 0;
        sbQueue.delete();
        @(negedge hash_clk);
        reset_n = 1'b1;
        checkOutput("mid_level", 32'(fifo_level), 32'd0);
        checkOutput("mid_send", 32'(txIf.serial_send), 32'd0);
        checkOutput("mid_golden", txIf.golden_nonce, 32'd0);
        repeat (40) @(negedge hash_clk);
        checkOutput("mid_no_sends", 32'(sendCount), 32'(base + 1));

        // Duplicate words from slaves 3 and 4 in consecutive cycles
        $display("[TB] duplicate reports");
        doReset();
        base = sendCount;
`ifdef NONCE_QUEUE_DEDUP_EN
        expSends = 1;
`else
        expSends = 2;
`endif
        for (int k = 0; k < expSends; k++) sbQueue.push_back(32'h1234);
        w = '0;
        w[3*32 +: 32] = 32'h1234;
        w[4*32 +: 32] = 32'h1234;
        applyStimulus(5'b01000, w);
        applyStimulus(5'b10000, w);
        applyStimulus(5'b00000, w);
        waitSends(base + expSends, 60, "dup_sends");
        repeat (20) @(negedge hash_clk);
        checkOutput("dup_exact", 32'(sendCount), 32'(base + expSends));
        checkOutput("dup_lost", 32'(lost_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
